// File: rtl/div_pkg.sv
// Shared types and sizes for the sequential signed divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH + 1);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // Partial remainder stays below divisor, so the shifted value always fits in WIDTH+1 bits.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign trial   = rem_sh - {1'b0, divisor};
  assign rem_nxt = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};

endmodule

// File: rtl/div_seq_unit.sv
// Iterative signed restoring divider: hi = remainder, lo = quotient, MIPS truncation semantics.
// Optional early-out for |dividend| < |divisor| is enabled by defining DIV_FAST_EN.
module div_seq_unit
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  div_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
  logic             sign_q_q, sign_r_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dz_q;

  logic [WIDTH-1:0] a_abs_c, b_abs_c;
  logic [WIDTH-1:0] rem_nxt_c, quo_nxt_c;
  logic             early_c;

  // Two's-complement magnitudes; the most negative value maps onto itself and is treated as unsigned.
  assign a_abs_c = dividend[WIDTH-1] ? WIDTH'(~dividend + 1'b1) : dividend;
  assign b_abs_c = divisor[WIDTH-1]  ? WIDTH'(~divisor + 1'b1)  : divisor;

`ifdef DIV_FAST_EN
  assign early_c = (a_abs_c < b_abs_c);
`else
  assign early_c = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt_c),
    .quo_nxt (quo_nxt_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              dvs_q    <= b_abs_c;
              sign_q_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r_q <= dividend[WIDTH-1];
              rem_q    <= early_c ? a_abs_c : '0;
              quo_q    <= early_c ? '0 : a_abs_c;
              cnt_q    <= CNT_W'(WIDTH);
              busy_q   <= 1'b1;
              state_q  <= early_c ? FIX : CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt_c;
          quo_q <= quo_nxt_c;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_q <= FIX;
        end
        FIX: begin
          lo_q    <= sign_q_q ? WIDTH'(~quo_q + 1'b1) : quo_q;
          hi_q    <= sign_r_q ? WIDTH'(~rem_q + 1'b1) : rem_q;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq_unit.sv
// Scoreboard bench for div_seq_unit: expected results queued at issue, popped on done.
module tb_div_seq_unit;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  exp_t        sb_q[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  div_seq_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] ph, input logic [31:0] pl);
    exp_t e;
    if (b == 32'd0) begin
      e = '{hi: ph, lo: pl, dz: 1'b1};
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e = '{hi: 32'd0, lo: 32'h8000_0000, dz: 1'b0};
    end else begin
      e.lo = 32'($signed(a) / $signed(b));
      e.hi = 32'($signed(a) % $signed(b));
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = a[31] ? -longint'($signed(a)) : longint'(a);
    mb = b[31] ? -longint'($signed(b)) : longint'(b);
`ifdef DIV_FAST_EN
    if (ma < mb) return 1;
`endif
    return (ma < 0 || mb < 0) ? 0 : 33;
  endfunction

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
    check({tag, "_dz"}, 32'(div_zero), 32'(e.dz));
    last_hi = e.hi;
    last_lo = e.lo;
  endtask

  // Issues one operation starting at the current cycle; optionally re-pulses start mid-operation.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int inject_at);
    int n;
    bit busy_ok;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb_q.push_back(model(a, b, last_hi, last_lo));
    @(posedge clk) #1;
    start = 1'b0;
    if (b == 32'd0) begin
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      compare_result(tag);
      @(posedge clk) #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_dz_pulse"}, 32'(div_zero), 32'd0);
      return;
    end
    check({tag, "_busy_e0"}, 32'(busy), 32'd1);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (inject_at != 0 && n == inject_at - 1) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd3;
      end
      @(posedge clk) #1;
      start = 1'b0;
      n++;
      if (!done && !busy) busy_ok = 1'b0;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_latency(a, b)));
    check({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, "_busy_drop"}, 32'(busy), 32'd0);
    compare_result(tag);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);

    run_op("p100_7", 32'd100, 32'd7, 0);
    run_op("n100_7", -32'sd100, 32'd7, 0);
    run_op("p100_n7", 32'd100, -32'sd7, 0);
    run_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("dz55", 32'd55, 32'd0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Reset lands on E10 of a running operation.
    dividend = 32'd1000;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    last_hi = '0;
    last_lo = '0;
    run_op("p12_4", 32'd12, 32'd4, 0);

    run_op("inject", 32'd1000, -32'sd7, 5);
    repeat (3) @(posedge clk);
    #1;
    check("inject_idle", 32'(busy), 32'd0);

    run_op("p5_9", 32'd5, 32'd9, 0);
    run_op("min_7", 32'h8000_0000, 32'd7, 0);
    run_op("n7_min", -32'sd7, 32'h8000_0000, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 255));
      if (rb == 32'd0) rb = 32'd1;
      run_op($sformatf("rnd%0d", i), ra, rb, 0);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
